// File: rtl/vram_writer_pkg.sv
// Shared video constants and the buffered-write entry type for the CPU-side
// video RAM write path.
package vram_writer_pkg;

    localparam int          VRAM_AW          = 14;
    localparam logic [1:0]  WIN_VIDEO        = 2'b01;
    localparam logic [7:0]  BORDER_PORT_MASK = 8'h01;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         data;
    } vram_entry_t;

endpackage

// File: rtl/vram_writer_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head entry is presented
// combinationally on dout.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_writer.sv
// CPU write port into video RAM: buffers window writes, commits them in slots
// the video adapter has not claimed, and latches the ULA border colour.
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [1:0] WIN   = WIN_VIDEO
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpu_we,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_data,
    output logic               cpu_wait,
    input  logic               io_we,
    input  logic [7:0]         io_addr,
    input  logic [7:0]         io_data,
    input  logic               vid_req,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_data,
    output logic               vram_we,
    output logic               pending,
    output logic [2:0]         vga_border
);

    localparam int CW = $clog2(DEPTH) + 1;

    vram_entry_t w_push_entry;
    vram_entry_t w_head;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;
    logic        w_push;
    logic        w_pop;
    logic        w_border_hit;

    logic [VRAM_AW-1:0] r_vram_addr;
    logic [7:0]         r_vram_data;
    logic               r_vram_we;
    logic [2:0]         r_border;

    assign w_push_entry.addr = cpu_addr[VRAM_AW-1:0];
    assign w_push_entry.data = cpu_data;

    // A refused write is simply dropped; the CPU retries until cpu_wait is low.
    assign w_push = cpu_we && (cpu_addr[15:14] == WIN) && !w_full;
    assign w_pop  = !w_empty && !vid_req;

    assign w_border_hit = io_we && ((io_addr & BORDER_PORT_MASK) == 8'h00);

    sync_fifo #(
        .WIDTH ($bits(vram_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_push_entry),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vram_addr <= '0;
            r_vram_data <= '0;
            r_vram_we   <= 1'b0;
        end else begin
            r_vram_we <= w_pop;
            if (w_pop) begin
                r_vram_addr <= w_head.addr;
                r_vram_data <= w_head.data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_border <= 3'b000;
        end else if (w_border_hit) begin
            r_border <= io_data[2:0];
        end
    end

    assign cpu_wait   = w_full;
    assign pending    = (w_count != '0);
    assign vram_addr  = r_vram_addr;
    assign vram_data  = r_vram_data;
    assign vram_we    = r_vram_we;
    assign vga_border = r_border;

endmodule

// File: tb/tb_vram_writer.sv
// Randomized and directed bench for vram_writer against a queue-based model.
module tb_vram_writer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_wait;
    logic        io_we = 1'b0;
    logic [7:0]  io_addr = '0;
    logic [7:0]  io_data = '0;
    logic        vid_req = 1'b0;
    logic [13:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_we;
    logic        pending;
    logic [2:0]  vga_border;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of {addr,data} plus the last committed write.
    logic [21:0] m_q[$];
    logic [13:0] m_addr;
    logic [7:0]  m_data;
    logic        m_we;
    logic [2:0]  m_border;

    vram_writer #(.DEPTH(DEPTH), .WIN(2'b01)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_wait   (cpu_wait),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_data    (io_data),
        .vid_req    (vid_req),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .vram_we    (vram_we),
        .pending    (pending),
        .vga_border (vga_border)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cpu_wait"},   32'(cpu_wait),   32'(m_q.size() == DEPTH));
        check({tag, ".pending"},    32'(pending),    32'(m_q.size() != 0));
        check({tag, ".vram_we"},    32'(vram_we),    32'(m_we));
        check({tag, ".vram_addr"},  32'(vram_addr),  32'(m_addr));
        check({tag, ".vram_data"},  32'(vram_data),  32'(m_data));
        check({tag, ".vga_border"}, 32'(vga_border), 32'(m_border));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_addr   = '0;
        m_data   = '0;
        m_we     = 1'b0;
        m_border = 3'b000;
    endtask

    // One clock: evaluate the model on the pre-edge inputs, clock, then compare.
    task automatic step(input string tag);
        bit full_now;
        full_now = (m_q.size() == DEPTH);
        m_we = 1'b0;
        if (m_q.size() > 0 && !vid_req) begin
            m_we   = 1'b1;
            m_addr = m_q[0][21:8];
            m_data = m_q[0][7:0];
            void'(m_q.pop_front());
        end
        if (cpu_we && cpu_addr[15:14] == 2'b01 && !full_now)
            m_q.push_back({cpu_addr[13:0], cpu_data});
        if (io_we && !io_addr[0])
            m_border = io_data[2:0];
        if (m_q.size() > DEPTH)
            check({tag, ".model_overflow"}, 32'(m_q.size()), 32'(DEPTH));
        @(posedge clock);
        #1;
        check_all(tag);
        cpu_we = 1'b0;
        io_we  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_we   = 1'b1;
        step(tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 1: reset with three entries buffered
        vid_req = 1'b1;
        wr("t1_push", 16'h4010, 8'h11);
        wr("t1_push", 16'h4011, 8'h22);
        wr("t1_push", 16'h4012, 8'h33);
        check("t1_pending_before", 32'(pending), 32'd1);
        pulse_reset("t1_reset");
        vid_req = 1'b0;
        for (int i = 0; i < 5; i++) step("t1_idle");

        // 2: single write, one-cycle latency
        wr("t2_push", 16'h4123, 8'h5A);
        step("t2_commit");
        check("t2_we", 32'(vram_we), 32'd1);
        check("t2_addr", 32'(vram_addr), 32'h0123);
        check("t2_data", 32'(vram_data), 32'h5A);
        step("t2_after");
        check("t2_we_low", 32'(vram_we), 32'd0);

        // 3: adapter owns the port while the FIFO fills
        vid_req = 1'b1;
        for (int i = 0; i < 4; i++) wr("t3_push", 16'h4000 + 16'(i), 8'(i + 1));
        check("t3_wait", 32'(cpu_wait), 32'd1);
        wr("t3_refused", 16'h4004, 8'h05);
        for (int i = 0; i < 5; i++) step("t3_hold");
        vid_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("t3_drain");
            check("t3_order", 32'(vram_data), 32'(i + 1));
        end
        step("t3_empty");
        check("t3_wait_clear", 32'(cpu_wait), 32'd0);

        // 4: writes outside the window
        wr("t4_hi", 16'h8000, 8'hAA);
        wr("t4_lo", 16'h3FFF, 8'hBB);
        check("t4_pending", 32'(pending), 32'd0);
        step("t4_idle");

        // 5: 1,1,0,0 request pattern with a push every cycle
        for (int i = 0; i < 40; i++) begin
            vid_req  = ((i % 4) < 2);
            cpu_addr = {2'b01, 14'($urandom)};
            cpu_data = 8'($urandom);
            cpu_we   = 1'b1;
            step("t5_stream");
        end
        vid_req = 1'b0;
        for (int i = 0; i < 6; i++) step("t5_drain");

        // 6: border port decode, concurrent with a commit
        io_addr = 8'hFE; io_data = 8'h15; io_we = 1'b1;
        step("t6_even");
        check("t6_border", 32'(vga_border), 32'h5);
        io_addr = 8'hFF; io_data = 8'h02; io_we = 1'b1;
        step("t6_odd");
        wr("t6_push", 16'h5555, 8'hC3);
        io_addr = 8'h00; io_data = 8'h03; io_we = 1'b1;
        step("t6_both");
        check("t6_both_we", 32'(vram_we), 32'd1);
        check("t6_both_border", 32'(vga_border), 32'h3);

        // random traffic, with occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            vid_req  = ($urandom_range(0, 9) < 4);
            cpu_we   = ($urandom_range(0, 9) < 6);
            cpu_addr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) cpu_addr[15:14] = 2'b01;
            cpu_data = 8'($urandom);
            io_we    = ($urandom_range(0, 9) < 2);
            io_addr  = 8'($urandom);
            io_data  = 8'($urandom);
            step("rand");
            if ($urandom_range(0, 199) == 0) pulse_reset("rand_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
CPU-side write port into the 16 KB video RAM. The video adapter reads this same memory through its scan-out port.
- Captures Z80 memory writes that fall in the video window and buffers them in a small FIFO.
- Commits each buffered write to the RAM write port only in cycles the adapter has not claimed, so scan-out fetches never collide with CPU writes.
- Also decodes the ULA border OUT and drives the adapter's 3-bit border colour.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
WIN, 2'b01, value of cpu_addr[15:14] that selects the video window (0x4000-0x7FFF)

Ports:
clock  in  1  system clock (same domain as the RAM port)
reset_n  in  1  asynchronous, active-low reset
cpu_we  in  1  one-cycle memory write strobe from the CPU
cpu_addr  in  16  CPU write address
cpu_data  in  8  CPU write data
cpu_wait  out  1  FIFO full; the CPU must hold and retry its write
io_we  in  1  one-cycle I/O write strobe
io_addr  in  8  I/O port, low byte
io_data  in  8  I/O write data
vid_req  in  1  high = adapter owns the RAM port in the NEXT cycle
vram_addr  out  14  RAM write address
vram_data  out  8  RAM write data
vram_we  out  1  RAM write enable
pending  out  1  FIFO not empty
vga_border  out  3  border colour to the video adapter

Behaviour:
Reset (async, reset_n low):
- Empty FIFO and zero count.
- All outputs low, including vram_addr=0, vram_data=0 and vga_border=3'b000.
- On reset mid-operation, all buffered writes are discarded.

Push:
- At a clock edge with cpu_we=1 and cpu_addr[15:14]==WIN and cpu_wait=0, enqueue {cpu_addr[13:0], cpu_data}.
- A write outside the window is ignored and does not set cpu_wait.

cpu_wait:
- Registered: equals (count==DEPTH) after each edge.
- A push while cpu_wait=1 is ignored, even if a pop occurs in the same cycle.
- The CPU holds the write until cpu_wait=0 is sampled.

Pop/commit:
- At a clock edge where count>0 and vid_req=0: load vram_addr/vram_data from the head, set vram_we=1 for exactly one cycle, and pop.
- Otherwise vram_we=0; vram_addr/vram_data hold their last values.

Latency and ordering:
- Minimum latency from push edge to vram_we high is 1 cycle, because the pop sees the entry on the next edge.
- Write order is preserved strictly.
- Repeated writes to the same address are committed separately, with no merging.

Simultaneous push+pop: count is unchanged and the pointers both advance.

Pointer arithmetic:
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Count is log2(DEPTH)+1 bits and never leaves 0..DEPTH.

pending: combinational (count!=0).

Starvation: none is handled. The adapter's demand leaves at least 14 of every 16 slots free, so no timeout is provided.

Border:
- At a clock edge with io_we=1 and io_addr[0]==0, set vga_border <= io_data[2:0]; odd ports are ignored.
- Independent of the FIFO; takes effect one cycle after the edge.

Decomposition:
- Shared package, video constants: VRAM_AW=14, WIN_VIDEO=2'b01, BORDER_PORT_MASK, and the FIFO entry struct {addr[13:0], data[7:0]}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable elsewhere.
- Window decode, commit register and border latch stay in vram_writer.

Test Plan:
1. Reset while 3 entries are buffered -> after release: pending=0, vram_we=0, vga_border=0, and no stale commits follow.
2. Single write 0x4123<=0x5A with vid_req=0 -> next edge: vram_we=1, vram_addr=0x0123, vram_data=0x5A; vram_we=0 the cycle after.
3. vid_req=1 held 10 cycles while 4 writes are pushed (0x4000..0x4003 <= 1..4) -> cpu_wait=1 after the 4th; a 5th write is refused; after vid_req drops, 4 in-order commits occur on consecutive cycles, then cpu_wait=0.
4. Write to 0x8000 and to 0x3FFF -> no enqueue, pending stays 0, cpu_wait stays 0.
5. vid_req toggling with pattern 1,1,0,0 repeating plus a push every cycle -> a commit only follows cycles with vid_req=0, pushes and pops overlap, and count never exceeds 4.
6. OUT 0xFE <= 0x15 -> vga_border=3'b101; OUT 0xFF <= 0x02 -> unchanged; border write concurrent with a FIFO commit -> both take effect.
